// File: rtl/alu_issue_if.sv
// Producer-side ALU issue bus: upstream instruction/operand handshake and the
// downstream operand/opcode handshake toward the integer ALU.
interface alu_issue_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [XLEN-1:0]       in_rs1_val;
  logic [XLEN-1:0]       in_rs2_val;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_a;
  logic [XLEN-1:0]       out_b;
  logic [2:0]            out_funct3;
  logic [6:0]            out_funct7;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_illegal;

  modport master (
    output in_valid, in_instr, in_rs1_val, in_rs2_val, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_funct3, out_funct7, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_rs1_val, in_rs2_val, out_ready,
    output in_ready, out_valid, out_a, out_b, out_funct3, out_funct7, out_rd, out_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// Decode/issue stage for OP / OP-IMM with a registered main entry plus skid entry.
// Optional macro ALU_ISSUE_PERF_CNT_EN adds perf_issued / perf_stall counters.
module alu_issue #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  alu_issue_if.slave  bus
`ifdef ALU_ISSUE_PERF_CNT_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]       a;
    logic [XLEN-1:0]       b;
    logic [2:0]            f3;
    logic [6:0]            f7;
    logic [REG_ADDR_W-1:0] rd;
    logic                  ill;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, dec;
  logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, in_ready_q, in_ready_d;
  logic   accept, main_free, legal;
  logic [6:0]      opcode, f7_in, f7_out;
  logic [2:0]      f3_in;
  logic [XLEN-1:0] b_val;

  assign opcode = bus.in_instr[6:0];
  assign f3_in  = bus.in_instr[14:12];
  assign f7_in  = bus.in_instr[31:25];

  // Decode the incoming word into an ALU entry; illegal words collapse to a zero entry.
  always_comb begin
    legal  = 1'b0;
    b_val  = '0;
    f7_out = 7'b0000000;
    dec    = '0;
    case (opcode)
      7'b0010011: begin
        case (f3_in)
          3'b001: begin
            b_val  = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
            f7_out = f7_in;
            legal  = (f7_in == 7'b0000000);
          end
          3'b101: begin
            b_val  = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
            f7_out = f7_in;
            legal  = (f7_in == 7'b0000000) || (f7_in == 7'b0100000);
          end
          3'b010, 3'b011: begin
            legal = 1'b0;
          end
          default: begin
            b_val  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
            f7_out = 7'b0000000;
            legal  = 1'b1;
          end
        endcase
      end
      7'b0110011: begin
        b_val  = bus.in_rs2_val;
        f7_out = f7_in;
        legal  = (f3_in != 3'b010) && (f3_in != 3'b011) &&
                 ((f7_in == 7'b0000000) ||
                  ((f7_in == 7'b0100000) && ((f3_in == 3'b000) || (f3_in == 3'b101))));
      end
      default: begin
        legal = 1'b0;
      end
    endcase
    if (legal) begin
      dec.a   = bus.in_rs1_val;
      dec.b   = b_val;
      dec.f3  = f3_in;
      dec.f7  = f7_out;
      dec.rd  = bus.in_instr[11:7];
      dec.ill = 1'b0;
    end else begin
      dec     = '0;
      dec.ill = 1'b1;
    end
  end

  assign accept    = bus.in_valid && in_ready_q;
  assign main_free = !main_vld_q || bus.out_ready;

  // Two-entry FIFO next state; skid drains into main before any new word lands there.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (main_free) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = dec;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else begin
      if (accept) begin
        skid_d     = dec;
        skid_vld_d = 1'b1;
      end else begin
        skid_vld_d = skid_vld_q;
      end
    end
    in_ready_d = !skid_vld_d;
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_vld_q;
  assign bus.out_a       = main_q.a;
  assign bus.out_b       = main_q.b;
  assign bus.out_funct3  = main_q.f3;
  assign bus.out_funct7  = main_q.f7;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_illegal = main_q.ill;

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [31:0] perf_issued_q, perf_stall_q;

  // Issue/stall counters; deliberately blind to flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_issued_q <= 32'd0;
      perf_stall_q  <= 32'd0;
    end else begin
      if (main_vld_q && bus.out_ready) begin
        perf_issued_q <= perf_issued_q + 32'd1;
      end else begin
        perf_issued_q <= perf_issued_q;
      end
      if (main_vld_q && !bus.out_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end else begin
        perf_stall_q <= perf_stall_q;
      end
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule
